// File: rtl/bp_pkg.sv
// Shared types, opcode constants and immediate decoders for the fetch-stage branch predictor.
// Widths here are the maximum supported address width; users slice down to ADDRESS_SIZE.
package bp_pkg;

  localparam int unsigned ADDR_W_MAX = 64;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    CtrSnt = 2'b00,
    CtrWnt = 2'b01,
    CtrWt  = 2'b10,
    CtrSt  = 2'b11
  } ctr2_t;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_W_MAX-1:0] tag;
    logic [ADDR_W_MAX-1:0] target;
    ctr2_t                 ctr;
  } btb_entry_t;

  function automatic logic [ADDR_W_MAX-1:0] imm_b(input logic [31:0] instr);
    logic [12:0] imm;
    imm = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    return {{(ADDR_W_MAX-13){imm[12]}}, imm};
  endfunction

  function automatic logic [ADDR_W_MAX-1:0] imm_j(input logic [31:0] instr);
    logic [20:0] imm;
    imm = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    return {{(ADDR_W_MAX-21){imm[20]}}, imm};
  endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped BTB storage: combinational lookup port plus a registered update/allocate port.
module btb_table
  import bp_pkg::*;
#(
  parameter int unsigned BTB_SIZE = 64
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [$clog2(BTB_SIZE)-1:0]         rd_idx,
  input  logic [ADDR_W_MAX-1:0]               rd_tag,
  output logic                                rd_hit,
  output logic                                rd_taken,
  output logic [ADDR_W_MAX-1:0]               rd_target,
  input  logic                                upd_valid,
  input  logic [$clog2(BTB_SIZE)-1:0]         upd_idx,
  input  logic [ADDR_W_MAX-1:0]               upd_tag,
  input  logic                                upd_taken,
  input  logic [ADDR_W_MAX-1:0]               upd_target
);

  btb_entry_t mem_q [BTB_SIZE];

  btb_entry_t rd_entry;
  btb_entry_t upd_entry;
  logic       upd_hit;
  ctr2_t      ctr_d;

  always_comb begin
    rd_entry  = mem_q[rd_idx];
    rd_hit    = rd_entry.valid && (rd_entry.tag == rd_tag);
    rd_taken  = rd_entry.ctr[1];
    rd_target = rd_entry.target;
  end

  always_comb begin
    upd_entry = mem_q[upd_idx];
    upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);
    ctr_d     = upd_entry.ctr;
    unique case (upd_entry.ctr)
      CtrSnt: ctr_d = upd_taken ? CtrWnt : CtrSnt;
      CtrWnt: ctr_d = upd_taken ? CtrWt  : CtrSnt;
      CtrWt:  ctr_d = upd_taken ? CtrSt  : CtrWnt;
      CtrSt:  ctr_d = upd_taken ? CtrSt  : CtrWt;
      default: ctr_d = CtrWnt;
    endcase
  end

  // Tags and targets are left untouched by reset; only valid and ctr matter.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(BTB_SIZE); i++) begin
        mem_q[i].valid <= 1'b0;
        mem_q[i].ctr   <= CtrWnt;
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        mem_q[upd_idx].ctr <= ctr_d;
        if (upd_taken) begin
          mem_q[upd_idx].target <= upd_target;
        end
      end else if (upd_taken) begin
        mem_q[upd_idx] <= '{valid: 1'b1, tag: upd_tag, target: upd_target, ctr: CtrWt};
      end
    end
  end

endmodule

// File: rtl/branch_target_predictor.sv
// Fetch-stage predictor: decodes the fetched word, consults the BTB for conditional branches and
// falls back to backward-taken/forward-not-taken on a miss.
module branch_target_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ADDRESS_SIZE     = 64,
  parameter int unsigned INSTRUCTION_SIZE = 32,
  parameter int unsigned BTB_SIZE         = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADDRESS_SIZE-1:0]     pc,
  input  logic [INSTRUCTION_SIZE-1:0] instruction,
  output logic [ADDRESS_SIZE-1:0]     next_pc,
  output logic                        overwrite_pc,
  output logic                        btb_hit,
  input  logic                        update_valid,
  input  logic [ADDRESS_SIZE-1:0]     update_pc,
  input  logic                        update_taken,
  input  logic [ADDRESS_SIZE-1:0]     update_target
);

  localparam int unsigned IDX_W = $clog2(BTB_SIZE);

  logic [IDX_W-1:0]      rd_idx;
  logic [IDX_W-1:0]      upd_idx;
  logic [ADDR_W_MAX-1:0] rd_tag;
  logic [ADDR_W_MAX-1:0] upd_tag;
  logic [ADDR_W_MAX-1:0] upd_target_ext;
  logic                  rd_hit;
  logic                  rd_taken;
  logic [ADDR_W_MAX-1:0] rd_target;
  logic [ADDR_W_MAX-1:0] imm_b_full;
  logic [ADDR_W_MAX-1:0] imm_j_full;
  logic [ADDRESS_SIZE-1:0] seq_pc;
  logic [6:0]            opcode;
  logic                  unused_bits;

  assign rd_idx         = pc[IDX_W+1:2];
  assign upd_idx        = update_pc[IDX_W+1:2];
  assign rd_tag         = ADDR_W_MAX'(pc[ADDRESS_SIZE-1:IDX_W+2]);
  assign upd_tag        = ADDR_W_MAX'(update_pc[ADDRESS_SIZE-1:IDX_W+2]);
  assign upd_target_ext = ADDR_W_MAX'(update_target);
  assign imm_b_full     = imm_b(instruction[31:0]);
  assign imm_j_full     = imm_j(instruction[31:0]);
  assign opcode         = instruction[6:0];
  assign seq_pc         = pc + ADDRESS_SIZE'(4);
  assign unused_bits    = ^{pc[1:0], update_pc[1:0]};

  btb_table #(
    .BTB_SIZE (BTB_SIZE)
  ) u_btb_table (
    .clk        (clk),
    .reset      (reset),
    .rd_idx     (rd_idx),
    .rd_tag     (rd_tag),
    .rd_hit     (rd_hit),
    .rd_taken   (rd_taken),
    .rd_target  (rd_target),
    .upd_valid  (update_valid),
    .upd_idx    (upd_idx),
    .upd_tag    (upd_tag),
    .upd_taken  (update_taken),
    .upd_target (upd_target_ext)
  );

  always_comb begin
    next_pc      = seq_pc;
    overwrite_pc = 1'b0;
    btb_hit      = 1'b0;
    if (!reset) begin
      if (opcode == OP_JAL) begin
        next_pc      = pc + imm_j_full[ADDRESS_SIZE-1:0];
        overwrite_pc = 1'b1;
      end else if (opcode == OP_BRANCH) begin
        if (rd_hit) begin
          btb_hit = 1'b1;
          if (rd_taken) begin
            next_pc      = rd_target[ADDRESS_SIZE-1:0];
            overwrite_pc = 1'b1;
          end
        end else if (instruction[31]) begin
          next_pc      = pc + imm_b_full[ADDRESS_SIZE-1:0];
          overwrite_pc = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed self-checking bench for branch_target_predictor with hand-computed expectations.
module tb_branch_target_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] pc;
  logic [31:0] instruction;
  logic [63:0] next_pc;
  logic        overwrite_pc;
  logic        btb_hit;
  logic        update_valid;
  logic [63:0] update_pc;
  logic        update_taken;
  logic [63:0] update_target;

  int compared   = 0;
  int mismatched = 0;

  branch_target_predictor #(
    .ADDRESS_SIZE     (64),
    .INSTRUCTION_SIZE (32),
    .BTB_SIZE         (64)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pc            (pc),
    .instruction   (instruction),
    .next_pc       (next_pc),
    .overwrite_pc  (overwrite_pc),
    .btb_hit       (btb_hit),
    .update_valid  (update_valid),
    .update_pc     (update_pc),
    .update_taken  (update_taken),
    .update_target (update_target)
  );

  always #5 clk = ~clk;

  // B-type encoding with zero registers/funct3.
  function automatic logic [31:0] mk_br(input int imm);
    logic [12:0] i;
    i = imm[12:0];
    return {i[12], i[10:5], 5'd0, 5'd0, 3'd0, i[4:1], i[11], 7'b1100011};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [63:0] a, input logic [31:0] ins);
    pc          = a;
    instruction = ins;
    #1;
  endtask

  task automatic upd(input logic [63:0] a, input logic t, input logic [63:0] tgt);
    update_valid  = 1'b1;
    update_pc     = a;
    update_taken  = t;
    update_target = tgt;
  endtask

  task automatic chk(input string tag, input logic [63:0] exp_pc, input logic exp_ow,
                     input logic exp_hit);
    compared++;
    assert (next_pc === exp_pc) else begin
      mismatched++;
      $error("FAIL %s next_pc: observed %h expected %h", tag, next_pc, exp_pc);
    end
    compared++;
    assert (overwrite_pc === exp_ow) else begin
      mismatched++;
      $error("FAIL %s overwrite_pc: observed %b expected %b", tag, overwrite_pc, exp_ow);
    end
    compared++;
    assert (btb_hit === exp_hit) else begin
      mismatched++;
      $error("FAIL %s btb_hit: observed %b expected %b", tag, btb_hit, exp_hit);
    end
  endtask

  initial begin
    reset         = 1'b1;
    update_valid  = 1'b0;
    update_pc     = '0;
    update_taken  = 1'b0;
    update_target = '0;
    look(64'h2000, mk_br(-16));
    tick();
    chk("reset_forced", 64'h2004, 1'b0, 1'b0);
    tick();
    reset = 1'b0;

    look(64'h1000, mk_br(-16));
    chk("cold_backward", 64'h0FF0, 1'b1, 1'b0);
    look(64'h1000, mk_br(32));
    chk("cold_forward", 64'h1004, 1'b0, 1'b0);
    look(64'h1000, 32'h0000_0013);
    chk("non_branch", 64'h1004, 1'b0, 1'b0);

    // Allocate 0x2000; the lookup in the same cycle still sees the empty entry.
    upd(64'h2000, 1'b1, 64'h2040);
    look(64'h2000, mk_br(32));
    chk("alloc_same_cycle", 64'h2004, 1'b0, 1'b0);
    tick();
    update_valid = 1'b0;
    look(64'h2000, mk_br(32));
    chk("learned_hit", 64'h2040, 1'b1, 1'b1);

    look(64'h2100, mk_br(32));
    chk("alias_fwd", 64'h2104, 1'b0, 1'b0);
    look(64'h2100, mk_br(-16));
    chk("alias_bwd", 64'h20F0, 1'b1, 1'b0);

    // WT -> ST, then ST -> WT -> WNT.
    upd(64'h2000, 1'b1, 64'h2040);
    tick();
    upd(64'h2000, 1'b0, 64'h0);
    tick();
    update_valid = 1'b0;
    look(64'h2000, mk_br(32));
    chk("st_one_nt", 64'h2040, 1'b1, 1'b1);
    upd(64'h2000, 1'b0, 64'h0);
    tick();
    update_valid = 1'b0;
    look(64'h2000, mk_br(32));
    chk("st_two_nt", 64'h2004, 1'b0, 1'b1);

    // WNT -> SNT; a hit overrides the static backward rule.
    upd(64'h2000, 1'b0, 64'h0);
    tick();
    update_valid = 1'b0;
    look(64'h2000, mk_br(-16));
    chk("snt_bwd_hit", 64'h2004, 1'b0, 1'b1);
    // SNT -> WNT still predicts not-taken.
    upd(64'h2000, 1'b1, 64'h2040);
    tick();
    update_valid = 1'b0;
    look(64'h2000, mk_br(32));
    chk("snt_one_t", 64'h2004, 1'b0, 1'b1);
    // WNT -> WT with a new target.
    upd(64'h2000, 1'b1, 64'h2080);
    tick();
    update_valid = 1'b0;
    look(64'h2000, mk_br(32));
    chk("new_target", 64'h2080, 1'b1, 1'b1);

    // Replace 0x2000 by 0x2100 while looking up 0x2000 in the same cycle.
    upd(64'h2100, 1'b1, 64'h2200);
    look(64'h2000, mk_br(32));
    chk("replace_same_cycle", 64'h2080, 1'b1, 1'b1);
    tick();
    update_valid = 1'b0;
    look(64'h2000, mk_br(32));
    chk("replaced_miss", 64'h2004, 1'b0, 1'b0);
    look(64'h2100, mk_br(32));
    chk("replaced_hit", 64'h2200, 1'b1, 1'b1);

    // Not-taken miss on the same index must not disturb the entry.
    upd(64'h3000, 1'b0, 64'h3333);
    tick();
    update_valid = 1'b0;
    look(64'h2100, mk_br(32));
    chk("nt_miss_nowrite", 64'h2200, 1'b1, 1'b1);
    look(64'h3000, mk_br(32));
    chk("nt_miss_noalloc", 64'h3004, 1'b0, 1'b0);

    look(64'h3000, 32'h1000_006F);
    chk("jal_cold", 64'h3100, 1'b1, 1'b0);
    look(64'h2100, 32'h1000_006F);
    chk("jal_ignores_btb", 64'h2200, 1'b1, 1'b0);

    // Relearn 0x2000, then reset for one cycle with an update pending.
    upd(64'h2000, 1'b1, 64'h2040);
    tick();
    update_valid = 1'b0;
    look(64'h2000, mk_br(32));
    chk("relearn", 64'h2040, 1'b1, 1'b1);
    reset = 1'b1;
    upd(64'h2000, 1'b1, 64'h2040);
    look(64'h2000, mk_br(32));
    chk("mid_reset_forced", 64'h2004, 1'b0, 1'b0);
    look(64'h2000, 32'h1000_006F);
    chk("mid_reset_jal", 64'h2004, 1'b0, 1'b0);
    tick();
    reset        = 1'b0;
    update_valid = 1'b0;
    look(64'h2000, mk_br(32));
    chk("post_reset_miss", 64'h2004, 1'b0, 1'b0);
    look(64'h2000, mk_br(-16));
    chk("post_reset_static", 64'h1FF0, 1'b1, 1'b0);

    look(64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_0013);
    chk("wrap_seq", 64'h0, 1'b0, 1'b0);
    look(64'hFFFF_FFFF_FFFF_FFF0, 32'h1000_006F);
    chk("wrap_jal", 64'h0F0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
